mux_arb_2x1: RTL and testbench

Two-requester arbiter and sequencer for the shared 2:1 one-bit mux datapath. It decides which requester owns the mux output and drives the select line. It registers the selected data bit and enforces round-robin fairness, with optional hold-time preemption. It sits between two producer blocks (A side, B side) and the single downstream consumer of the mux output.

---
 rtl/mux_arb_2x1.sv | 124 ++++++++++++
 tb/tb_mux_arb_2x1.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mux_arb_2x1.sv
// mux_arb_2x1
// Two-requester round-robin arbiter for a shared 2:1 one-bit mux. It decides
// which side owns the mux output, drives the select, and registers the
// selected data bit one cycle behind the grant.
//
// Optional feature macro: MUX_ARB_PREEMPT_EN
//   defined   - the owner is forced off after MAX_HOLD consecutive cycles
//               while the other side is requesting.
//   undefined - the owner keeps the grant until it drops its request; there is
//               no hold counter, and MAX_HOLD/CNT_W are only range-checked.
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   req0  in   requester 0 (A side) wants the output
//   req1  in   requester 1 (B side) wants the output
//   a     in   data bit from requester 0
//   b     in   data bit from requester 1
//   gnt0  out  requester 0 owns the output
//   gnt1  out  requester 1 owns the output
//   s0    out  mux select, 1 = B, 0 = A, low when idle
//   y     out  registered mux output, lags gnt/s0 by one cycle
//   busy  out  gnt0 | gnt1
module mux_arb_2x1 #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic a,
    input  logic b,
    output logic gnt0,
    output logic gnt1,
    output logic s0,
    output logic y,
    output logic busy
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state, nxt;
    logic   last;     // most recently granted side, 1 = requester 1
    logic   preempt;

    if (MAX_HOLD < 2 || MAX_HOLD > 8 || (1 << CNT_W) < MAX_HOLD) begin : g_param_chk
        $error("mux_arb_2x1: MAX_HOLD must be 2..8 and fit in CNT_W bits");
    end

`ifdef MUX_ARB_PREEMPT_EN
    logic [CNT_W-1:0] cnt;  // cycles held in the current OWN state, saturating
    assign preempt = (cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign preempt = 1'b0;
`endif

    // Next-state decode. From IDLE a tie goes to the side that did not own
    // last; an owner yields on release or, with preemption, when its hold
    // budget is spent and the other side is waiting.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req0 && !req1)      nxt = OWN0;
                else if (req1 && !req0) nxt = OWN1;
                else if (req0 && req1)  nxt = last ? OWN0 : OWN1;
            end
            OWN0: begin
                if (!req0)                  nxt = req1 ? OWN1 : IDLE;
                else if (req1 && preempt)   nxt = OWN1;
            end
            OWN1: begin
                if (!req1)                  nxt = req0 ? OWN0 : IDLE;
                else if (req0 && preempt)   nxt = OWN0;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            s0    <= 1'b0;
            y     <= 1'b0;
`ifdef MUX_ARB_PREEMPT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= nxt;
            // Grant/select registered from the next state so they are plain
            // flop outputs that match the state register exactly.
            gnt0  <= (nxt == OWN0);
            gnt1  <= (nxt == OWN1);
            s0    <= (nxt == OWN1);

            if (nxt != state) begin
                if (nxt == OWN0)      last <= 1'b0;
                else if (nxt == OWN1) last <= 1'b1;
            end

            // Data follows the owner of the current cycle, so y trails the
            // grant by one edge.
            case (state)
                OWN0:    y <= a;
                OWN1:    y <= b;
                default: y <= 1'b0;
            endcase

`ifdef MUX_ARB_PREEMPT_EN
            if (nxt != state || nxt == IDLE)
                cnt <= '0;
            else if (!preempt)
                cnt <= cnt + CNT_W'(1);
`endif
        end
    end

    assign busy = gnt0 | gnt1;

endmodule

// File: tb/tb_mux_arb_2x1.sv
// Self-checking bench for mux_arb_2x1. Expected outputs are derived by hand
// from the intended behaviour, queued when stimulus is applied and compared
// after the edge that consumes it. Works for both builds of the
// MUX_ARB_PREEMPT_EN option (MAX_HOLD = 4).
module tb_mux_arb_2x1;

    logic clk = 1'b0;
    logic rst, req0, req1, a, b;
    logic gnt0, gnt1, s0, y, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string tag;
        logic  g0;
        logic  g1;
        logic  y;
    } exp_t;

    exp_t exp_q[$];

    mux_arb_2x1 #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .req0(req0),
        .req1(req1),
        .a   (a),
        .b   (b),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .s0  (s0),
        .y   (y),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, want, $time);
        end
    endtask

    // Grants must be exclusive every cycle.
    always @(negedge clk) chk("mutex", gnt0 & gnt1, 1'b0);

    task automatic cmp_all(input exp_t e);
        chk({e.tag, ".gnt0"}, gnt0, e.g0);
        chk({e.tag, ".gnt1"}, gnt1, e.g1);
        chk({e.tag, ".s0"},   s0,   e.g1);
        chk({e.tag, ".y"},    y,    e.y);
        chk({e.tag, ".busy"}, busy, e.g0 | e.g1);
    endtask

    // Apply inputs, queue what the outputs must be after the next edge,
    // then sample on the falling edge and compare.
    task automatic cyc(input string tag, input logic r0, input logic r1,
                       input logic da, input logic db,
                       input logic eg0, input logic eg1, input logic ey);
        exp_t e;
        req0 = r0; req1 = r1; a = da; b = db;
        exp_q.push_back('{tag, eg0, eg1, ey});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        cmp_all(e);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic rst_pulse(input string tag);
        exp_t e;
        #2 rst = 1'b1;
        #1;
        e = '{tag, 1'b0, 1'b0, 1'b0};
        cmp_all(e);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic own, prev_own;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; a = 1'b0; b = 1'b0;

        // Reset held for two edges with req0 raised mid-reset.
        #2 req0 = 1'b1;
        @(negedge clk);
        cmp_all('{"rst0", 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        cmp_all('{"rst1", 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        cyc("rel0", 1, 0, 1, 0, 1, 0, 0);
        cyc("rel1", 1, 0, 1, 0, 1, 0, 1);
        cyc("rel2", 0, 0, 1, 0, 0, 0, 1);
        cyc("rel3", 0, 0, 0, 0, 0, 0, 0);

        // last is now 0; reset must restore it to 1 so requester 0 wins.
        rst_pulse("arst_idle");
        cyc("sim0", 1, 1, 0, 1, 1, 0, 0);
        cyc("sim1", 1, 1, 0, 1, 1, 0, 0);
        cyc("sim2", 0, 1, 0, 1, 0, 1, 0);   // handover, no idle bubble
        cyc("sim3", 0, 1, 0, 1, 0, 1, 1);
        cyc("sim4", 0, 0, 0, 0, 0, 0, 0);
        cyc("sim5", 0, 0, 0, 0, 0, 0, 0);

        // Single requester on the B side.
        cyc("one0", 0, 1, 0, 1, 0, 1, 0);
        cyc("one1", 0, 1, 0, 1, 0, 1, 1);
        cyc("one2", 0, 1, 0, 1, 0, 1, 1);
        cyc("one3", 0, 0, 0, 1, 0, 0, 1);
        cyc("one4", 0, 0, 0, 0, 0, 0, 0);

        // Both held for 16 cycles; a=1, b=0 so y identifies the owner.
        prev_own = 1'b0;
        for (int i = 0; i < 16; i++) begin
`ifdef MUX_ARB_PREEMPT_EN
            own = ((i / 4) % 2) == 1;
`else
            own = 1'b0;
`endif
            cyc($sformatf("hold%0d", i), 1, 1, 1, 0, !own, own,
                (i == 0) ? 1'b0 : !prev_own);
            prev_own = own;
        end
`ifdef MUX_ARB_PREEMPT_EN
        cyc("drop0", 0, 1, 1, 0, 0, 1, 0);  // B already owns, keeps it
        cyc("drop1", 0, 1, 1, 0, 0, 1, 0);
        cyc("sat",   1, 1, 1, 0, 1, 0, 0);  // saturated count preempts at once
        cyc("drop2", 0, 0, 1, 0, 0, 0, 1);
`else
        cyc("drop0", 0, 1, 1, 0, 0, 1, 1);  // B takes over on release
        cyc("drop1", 0, 1, 1, 0, 0, 1, 0);
        cyc("sat",   1, 1, 1, 0, 0, 1, 0);  // no preemption: B keeps it
        cyc("drop2", 0, 0, 1, 0, 0, 0, 0);
`endif
        cyc("drop3", 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-ownership: OWN1 with y=1, then contention from IDLE.
        cyc("mid0", 0, 1, 0, 1, 0, 1, 0);
        cyc("mid1", 0, 1, 0, 1, 0, 1, 1);
        req0 = 1'b1;
        rst_pulse("arst_own1");
        cyc("mid2", 1, 1, 0, 1, 1, 0, 0);
        cyc("mid3", 0, 0, 0, 1, 0, 0, 0);

        chk("q_empty", exp_q.size() == 0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
